// File: rtl/dso_cmd_pkg.sv
// Shared constants and types for the command dispatcher: opcodes, response codes,
// gain lookup table, slave-select codes and FSM states.
package dso_cmd_pkg;

  localparam logic [7:0] CFG_GAIN = 8'h02;
  localparam logic [7:0] SET_TRIG = 8'h03;
  localparam logic [7:0] WR_EEP   = 8'h08;
  localparam logic [7:0] RD_EEP   = 8'h09;

  localparam logic [7:0] ACK  = 8'hA5;
  localparam logic [7:0] NACK = 8'hEE;

  // Register address byte for analog front-end gain/trigger writes
  localparam logic [7:0] AFE_REG = 8'h13;

  // Element g holds the gain code for gain step g
  localparam logic [7:0][7:0] GAIN_LUT = {8'hDD, 8'h6B, 8'h46, 8'h28,
                                          8'h14, 8'h09, 8'h05, 8'h02};

  localparam int unsigned SS_NONE   = 0;
  localparam int unsigned SS_EEPROM = 1;

  typedef enum logic [2:0] {
    StIdle,
    StAccept,
    StDecode,
    StWaitSpi,
    StWaitSent
  } state_e;

endpackage

// File: rtl/cmd_decode.sv
// Combinational opcode decode: latched 24-bit command to slave select, SPI frame,
// validity and read flag.
module cmd_decode
  import dso_cmd_pkg::*;
#(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned SSW    = $clog2(NUM_CH + 3)
) (
  input  logic [23:0]    cmd,
  output logic           valid,
  output logic [SSW-1:0] ss,
  output logic [15:0]    spi_data,
  output logic           is_read
);

  logic [7:0] opcode;
  logic [7:0] arg1;
  logic [7:0] arg2;

  assign opcode = cmd[23:16];
  assign arg1   = cmd[15:8];
  assign arg2   = cmd[7:0];

  always_comb begin
    valid    = 1'b0;
    ss       = SSW'(SS_NONE);
    spi_data = '0;
    is_read  = 1'b0;
    case (opcode)
      CFG_GAIN: begin
        if (32'(arg1) < NUM_CH) begin
          valid    = 1'b1;
          ss       = SSW'(32'(arg1) + 32'd2);
          spi_data = {AFE_REG, GAIN_LUT[arg2[2:0]]};
        end
      end
      SET_TRIG: begin
        valid    = 1'b1;
        ss       = SSW'(NUM_CH + 32'd2);
        spi_data = {AFE_REG, arg2};
      end
      WR_EEP: begin
        // EEPROM has a 6-bit address space; upper arg1 bits must be clear
        if (arg1[7:6] == 2'b00) begin
          valid    = 1'b1;
          ss       = SSW'(SS_EEPROM);
          spi_data = {2'b01, arg1[5:0], arg2};
        end
      end
      RD_EEP: begin
        if (arg1[7:6] == 2'b00) begin
          valid    = 1'b1;
          ss       = SSW'(SS_EEPROM);
          spi_data = {2'b00, arg1[5:0], 8'h00};
          is_read  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cmd_dispatch.sv
// Command dispatcher: accepts one command, runs one SPI transaction (or NACKs it),
// then emits a response byte and waits for the transmitter to finish.
module cmd_dispatch
  import dso_cmd_pkg::*;
#(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned TO_CYC = 4096,
  parameter int unsigned SSW    = $clog2(NUM_CH + 3)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [23:0]    cmd,
  input  logic           cmd_rdy,
  output logic           clr_cmd_rdy,
  output logic [7:0]     resp_data,
  output logic           send_resp,
  input  logic           resp_sent,
  output logic [SSW-1:0] ss,
  output logic           wrt_SPI,
  output logic [15:0]    SPI_data,
  input  logic [7:0]     EEP_data,
  input  logic           SPI_done
);

  localparam int unsigned TW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TO_CYC - 1);

  state_e         state_q, state_d;
  logic [23:0]    cmd_q;
  logic [TW-1:0]  timer_q, timer_d;
  logic           clr_q, clr_d;
  logic           send_q, send_d;
  logic           wrt_q, wrt_d;
  logic [SSW-1:0] ss_q, ss_d;
  logic [15:0]    spi_q, spi_d;
  logic [7:0]     resp_q, resp_d;

  logic           dec_valid;
  logic [SSW-1:0] dec_ss;
  logic [15:0]    dec_spi;
  logic           dec_is_read;
  logic           timed_out;

  cmd_decode #(
    .NUM_CH (NUM_CH),
    .SSW    (SSW)
  ) u_cmd_decode (
    .cmd      (cmd_q),
    .valid    (dec_valid),
    .ss       (dec_ss),
    .spi_data (dec_spi),
    .is_read  (dec_is_read)
  );

  assign timed_out = (timer_q == TMAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cmd_q   <= '0;
      timer_q <= '0;
      clr_q   <= 1'b0;
      send_q  <= 1'b0;
      wrt_q   <= 1'b0;
      ss_q    <= '0;
      spi_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      clr_q   <= clr_d;
      send_q  <= send_d;
      wrt_q   <= wrt_d;
      ss_q    <= ss_d;
      spi_q   <= spi_d;
      resp_q  <= resp_d;
      if (state_q == StIdle && cmd_rdy) begin
        cmd_q <= cmd;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      StIdle:     if (cmd_rdy) state_d = StAccept;
      StAccept:   state_d = StDecode;
      StDecode: begin
        state_d = dec_valid ? StWaitSpi : StWaitSent;
        timer_d = '0;
      end
      StWaitSpi: begin
        if (SPI_done || timed_out) state_d = StWaitSent;
        if (!timed_out) timer_d = timer_q + TW'(1);
      end
      // A resp_sent arriving alongside send_resp belongs to no response yet
      StWaitSent: if (resp_sent && !send_q) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    clr_d  = 1'b0;
    send_d = 1'b0;
    wrt_d  = 1'b0;
    ss_d   = ss_q;
    spi_d  = spi_q;
    resp_d = resp_q;
    unique case (state_q)
      StAccept: clr_d = 1'b1;
      StDecode: begin
        if (dec_valid) begin
          wrt_d = 1'b1;
          ss_d  = dec_ss;
          spi_d = dec_spi;
        end else begin
          send_d = 1'b1;
          resp_d = NACK;
        end
      end
      StWaitSpi: begin
        if (SPI_done) begin
          ss_d   = SSW'(SS_NONE);
          send_d = 1'b1;
          resp_d = dec_is_read ? EEP_data : ACK;
        end else if (timed_out) begin
          ss_d   = SSW'(SS_NONE);
          send_d = 1'b1;
          resp_d = NACK;
        end
      end
      default: ;
    endcase
  end

  assign clr_cmd_rdy = clr_q;
  assign send_resp   = send_q;
  assign wrt_SPI     = wrt_q;
  assign ss          = ss_q;
  assign SPI_data    = spi_q;
  assign resp_data   = resp_q;

endmodule

// File: tb/tb_cmd_dispatch.sv
// Scoreboard bench for cmd_dispatch: directed cases plus randomized commands checked
// against a behavioural model of the command set.
module tb_cmd_dispatch;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned TO_CYC = 32;
  localparam int unsigned SSW    = $clog2(NUM_CH + 3);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [23:0]    cmd = '0;
  logic           cmd_rdy = 1'b0;
  logic           clr_cmd_rdy;
  logic [7:0]     resp_data;
  logic           send_resp;
  logic           resp_sent = 1'b0;
  logic [SSW-1:0] ss;
  logic           wrt_SPI;
  logic [15:0]    SPI_data;
  logic [7:0]     EEP_data = '0;
  logic           SPI_done = 1'b0;

  cmd_dispatch #(
    .NUM_CH (NUM_CH),
    .TO_CYC (TO_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp_data   (resp_data),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent),
    .ss          (ss),
    .wrt_SPI     (wrt_SPI),
    .SPI_data    (SPI_data),
    .EEP_data    (EEP_data),
    .SPI_done    (SPI_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ok;
    int          ss;
    logic [15:0] data;
    bit          rd;
  } exp_t;

  typedef struct {
    int          ss;
    logic [15:0] data;
  } spi_exp_t;

  spi_exp_t   exp_spi[$];
  logic [7:0] exp_resp[$];
  int total = 0;
  int bad = 0;
  int clr_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Command set written directly from the opcode rules with plain arithmetic
  function automatic exp_t model(input logic [23:0] c);
    exp_t m;
    int op, a1, a2;
    int lut[8];
    lut = '{'h02, 'h05, 'h09, 'h14, 'h28, 'h46, 'h6B, 'hDD};
    op = int'(c[23:16]);
    a1 = int'(c[15:8]);
    a2 = int'(c[7:0]);
    m.ok = 0; m.ss = 0; m.data = '0; m.rd = 0;
    if (op == 2 && a1 < NUM_CH) begin
      m.ok = 1; m.ss = a1 + 2; m.data = 16'('h1300 + lut[a2 % 8]);
    end else if (op == 3) begin
      m.ok = 1; m.ss = NUM_CH + 2; m.data = 16'('h1300 + a2);
    end else if (op == 8 && a1 < 64) begin
      m.ok = 1; m.ss = 1; m.data = 16'('h4000 + a1 * 256 + a2);
    end else if (op == 9 && a1 < 64) begin
      m.ok = 1; m.ss = 1; m.data = 16'(a1 * 256); m.rd = 1;
    end
    return m;
  endfunction

  // Monitor: pops expectations whenever the DUT presents an SPI frame or a response
  always @(negedge clk) begin
    if (rst_n) begin
      if (clr_cmd_rdy) clr_cnt++;
      if (wrt_SPI) begin
        if (exp_spi.size() == 0) begin
          check("unexpected_wrt_SPI", 32'd1, 32'd0);
        end else begin
          spi_exp_t e;
          e = exp_spi.pop_front();
          check("spi_ss", 32'(ss), 32'(e.ss));
          check("spi_data", 32'(SPI_data), 32'(e.data));
        end
      end
      if (send_resp) begin
        if (exp_resp.size() == 0) begin
          check("unexpected_send_resp", 32'd1, 32'd0);
        end else begin
          logic [7:0] r;
          r = exp_resp.pop_front();
          check("resp_data", 32'(resp_data), 32'(r));
          check("ss_released", 32'(ss), 32'd0);
        end
      end
    end
  end

  task automatic wait_clr();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!clr_cmd_rdy && n < 8);
    check("clr_latency", 32'(n), 32'd2);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {clr_cmd_rdy, send_resp, wrt_SPI, 5'(ss), SPI_data, resp_data}, 32'd0);
  endtask

  // One full transaction. d: cycles after wrt_SPI before SPI_done (>= TO_CYC withholds it).
  // sdel: cycles before resp_sent (0 also fires a pulse coincident with send_resp).
  task automatic run_cmd(input logic [23:0] c, input int d, input logic [7:0] eep,
                         input int sdel, input bit hold);
    exp_t m;
    logic [7:0] r;
    int n, base;
    m = model(c);
    if (!m.ok)             r = 8'hEE;
    else if (d >= TO_CYC)  r = 8'hEE;
    else if (m.rd)         r = eep;
    else                   r = 8'hA5;
    if (m.ok) exp_spi.push_back('{ss: m.ss, data: m.data});
    exp_resp.push_back(r);
    cmd = c;
    cmd_rdy = 1'b1;
    wait_clr();
    if (!hold) cmd_rdy = 1'b0;
    #1;
    base = clr_cnt;
    n = 0;
    if (m.ok) begin
      do begin
        @(negedge clk);
        n++;
      end while (!wrt_SPI && n < 4);
      check("wrt_latency", 32'(n), 32'd1);
      n = 0;
      while (1) begin
        if (n == d && d < TO_CYC) begin
          check("spi_hold", {8'(ss), SPI_data}, {8'(m.ss), m.data});
          SPI_done = 1'b1;
          EEP_data = eep;
        end
        @(negedge clk);
        SPI_done = 1'b0;
        EEP_data = 8'($urandom);
        n++;
        if (send_resp || n > int'(TO_CYC) + 4) break;
      end
      check("resp_latency", 32'(n), (d < TO_CYC) ? 32'(d + 1) : 32'(TO_CYC));
    end else begin
      do begin
        @(negedge clk);
        n++;
      end while (!send_resp && n < 4);
      check("nack_latency", 32'(n), 32'd1);
    end
    if (sdel == 0) begin
      resp_sent = 1'b1;
      @(negedge clk);
      resp_sent = 1'b0;
      repeat (2) @(negedge clk);
    end else begin
      repeat (sdel) @(negedge clk);
    end
    #1;
    check("resp_held", 32'(resp_data), 32'(r));
    check("send_once", 32'(send_resp), 32'd0);
    check("no_early_accept", 32'(clr_cnt), 32'(base));
    resp_sent = 1'b1;
    @(negedge clk);
    resp_sent = 1'b0;
  endtask

  task automatic reset_mid_spi();
    exp_t m;
    m = model(24'h08_01_55);
    exp_spi.push_back('{ss: m.ss, data: m.data});
    cmd = 24'h08_01_55;
    cmd_rdy = 1'b1;
    wait_clr();
    cmd_rdy = 1'b0;
    @(negedge clk);
    check("reset_test_wrt", 32'(wrt_SPI), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("reset_mid_spi_outputs");
    SPI_done = 1'b1;
    @(negedge clk);
    SPI_done = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("no_resp_after_abort");
  endtask

  initial begin
    logic [23:0] c;
    logic [7:0]  op, a1;
    int          r2, d;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle_outputs");

    run_cmd(24'h02_01_03, 2, 8'h00, 1, 0);
    run_cmd(24'h09_2A_00, 3, 8'h5C, 2, 0);
    run_cmd(24'h07_00_00, 0, 8'h00, 1, 0);
    run_cmd(24'h02_03_00, 0, 8'h00, 3, 0);
    run_cmd(24'h08_3F_AB, TO_CYC, 8'h00, 1, 0);
    run_cmd(24'h08_3F_AB, TO_CYC - 1, 8'h00, 1, 0);
    run_cmd(24'h09_40_00, 0, 8'h00, 1, 0);
    run_cmd(24'h03_00_80, 1, 8'h00, 50, 1);
    run_cmd(24'h02_00_07, 0, 8'h00, 0, 1);
    run_cmd(24'h02_02_05, 4, 8'h00, 1, 0);
    reset_mid_spi();
    run_cmd(24'h03_00_80, 2, 8'h00, 1, 0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0:       op = 8'h02;
        1:       op = 8'h03;
        2:       op = 8'h08;
        3:       op = 8'h09;
        default: op = 8'($urandom);
      endcase
      if (op == 8'h02)                     a1 = 8'($urandom_range(0, 4));
      else if ($urandom_range(0, 3) == 0)  a1 = 8'($urandom);
      else                                 a1 = 8'($urandom_range(0, 63));
      c = {op, a1, 8'($urandom)};
      r2 = int'($urandom_range(0, 9));
      if (r2 == 0)      d = TO_CYC - 1;
      else if (r2 == 1) d = TO_CYC;
      else              d = int'($urandom_range(0, 8));
      run_cmd(c, d, 8'($urandom), int'($urandom_range(0, 4)),
              (i < 39) && ($urandom_range(0, 3) == 0));
    end

    repeat (4) @(negedge clk);
    check("spi_queue_drained", 32'(exp_spi.size()), 32'd0);
    check("resp_queue_drained", 32'(exp_resp.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
